// File: rtl/timeout_scheduler.sv
// Retransmit timeout scheduler: per-flow armed bit and deadline, a round-robin
// scan pointer, and a single output slot that hands expired flows downstream.
`ifndef TIME_W
`define TIME_W 16
`endif
`ifndef TIMER_W
`define TIMER_W 8
`endif

module timeout_flow (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [`TIME_W-1:0]  now,
  input  logic                set_hit,
  input  logic [`TIMER_W-1:0] set_amnt,
  input  logic                clr_hit,
  output logic                armed,
  output logic                expired
);
  localparam int TW = `TIME_W;

  logic [TW-1:0] deadline, age;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       armed <= 1'b0;
    else if (set_hit) armed <= 1'b1;
    else if (clr_hit) armed <= 1'b0;

  always_ff @(posedge clk)
    if (set_hit) deadline <= now + TW'(set_amnt);

  // Modular difference: MSB clear means the deadline is at or behind now.
  assign age     = now - deadline;
  assign expired = armed & ~age[TW-1];
endmodule

module timeout_scheduler #(
  parameter int FLOW_CNT  = 16,
  parameter int FLOW_ID_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [`TIME_W-1:0]   now,
  input  logic                 set_valid,
  input  logic [FLOW_ID_W-1:0] set_fid,
  input  logic [`TIMER_W-1:0]  set_amnt,
  input  logic                 clr_valid,
  input  logic [FLOW_ID_W-1:0] clr_fid,
  output logic                 to_valid,
  output logic [FLOW_ID_W-1:0] to_fid,
  input  logic                 to_ready,
  output logic [FLOW_ID_W:0]   armed_cnt
);
  localparam int CW = FLOW_ID_W + 1;

  typedef enum logic {IDLE, HOLD} slot_t;

  slot_t                state, state_nxt;
  logic [FLOW_ID_W-1:0] ptr, ptr_nxt, fid_nxt;
  logic [FLOW_CNT-1:0]  armed, expired, set_hit, clr_req, clr_hit;
  logic                 slot_free, capture;
  logic [CW-1:0]        pop;

  for (genvar g = 0; g < FLOW_CNT; g++) begin : g_flow
    assign set_hit[g] = set_valid && (set_fid == FLOW_ID_W'(g));
    assign clr_req[g] = clr_valid && (clr_fid == FLOW_ID_W'(g));
    // Capture consumes the timer; set still wins inside the flow.
    assign clr_hit[g] = clr_req[g] || (capture && (ptr == FLOW_ID_W'(g)));

    timeout_flow u_flow (
      .clk      (clk),
      .rst_n    (rst_n),
      .now      (now),
      .set_hit  (set_hit[g]),
      .set_amnt (set_amnt),
      .clr_hit  (clr_hit[g]),
      .armed    (armed[g]),
      .expired  (expired[g])
    );
  end

  // A same-cycle set or clear on the scanned flow suppresses its capture.
  assign slot_free = (state == IDLE) || to_ready;
  assign capture   = slot_free && expired[ptr] && !set_hit[ptr] && !clr_req[ptr];
  assign to_valid  = (state == HOLD);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    fid_nxt   = to_fid;
    if (slot_free) begin
      ptr_nxt   = (ptr == FLOW_ID_W'(FLOW_CNT - 1)) ? '0 : ptr + 1'b1;
      state_nxt = IDLE;
    end
    if (capture) begin
      state_nxt = HOLD;
      fid_nxt   = ptr;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < FLOW_CNT; i++) pop = pop + CW'(armed[i]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      to_fid    <= '0;
      armed_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      to_fid    <= fid_nxt;
      armed_cnt <= pop;
    end
endmodule
